// File: rtl/user_id_pkg.sv
// Shared types and default sizes for the user project ID reader.
package user_id_pkg;

    localparam int unsigned DEFAULT_ID_WIDTH = 32;
    localparam int unsigned DEFAULT_DIV_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/user_id_bit_timer.sv
// Loadable down-counter that marks serial bit boundaries.
// A load captures both the count and the reload period; while enabled the
// counter ticks when it reaches zero and then reloads with the period.
module user_id_bit_timer #(
    parameter int unsigned DIV_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] period_q, period_d;

    // Counter next-state: load, reload on tick, or decrement.
    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        if (load_i) begin
            cnt_d    = load_val_i;
            period_d = load_val_i;
        end else if (en_i) begin
            if (cnt_q == '0) begin
                cnt_d = period_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Counter and period registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            period_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

    assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/user_id_reader.sv
// Reads the hard-wired user project ID into a shadow register and returns
// it in parallel, optionally preceded by an MSB-first serial stream with a
// trailing even-parity bit.
module user_id_reader
    import user_id_pkg::*;
#(
    parameter int unsigned ID_WIDTH = DEFAULT_ID_WIDTH,
    parameter int unsigned DIV_W    = DEFAULT_DIV_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [ID_WIDTH-1:0] mask_id,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_serial,
    input  logic [DIV_W-1:0]    div,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_WIDTH-1:0] rsp_data,
    output logic                rsp_parity,
    output logic                sdo,
    output logic                sdo_strobe,
    output logic                busy
);

    localparam int unsigned IDX_W = $clog2(ID_WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ID_WIDTH);

    state_e              state_q, state_d;
    logic [ID_WIDTH-1:0] shadow_q, shadow_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                sdo_q, sdo_d;

    logic                timer_load;
    logic                timer_tick;
    logic [ID_WIDTH-1:0] shifted;
    logic                cur_bit;

    user_id_bit_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (resetn),
        .load_i     (timer_load),
        .load_val_i (div),
        .en_i       (state_q == ST_SHIFT),
        .tick_o     (timer_tick)
    );

    // Bit currently due on the serial line: shadow MSB-first, then parity.
    always_comb begin
        shifted = shadow_q << idx_q;
        cur_bit = (idx_q == LAST_IDX) ? (^shadow_q) : shifted[ID_WIDTH-1];
    end

    // FSM next-state and handshake/strobe outputs.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        idx_d      = idx_q;
        sdo_d      = sdo_q;
        timer_load = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        sdo_strobe = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    shadow_d   = mask_id;
                    idx_d      = '0;
                    timer_load = 1'b1;
                    state_d    = req_serial ? ST_SHIFT : ST_RESP;
                end
            end
            ST_SHIFT: begin
                if (timer_tick) begin
                    sdo_strobe = 1'b1;
                    sdo_d      = cur_bit;
                    idx_d      = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    sdo_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, shadow word, bit index and held serial bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            sdo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            sdo_q    <= sdo_d;
        end
    end

    // sdo is built only from registers: the new bit shows in its strobe
    // cycle and the held copy covers every other cycle.
    assign sdo        = sdo_strobe ? cur_bit : sdo_q;
    assign rsp_data   = shadow_q;
    assign rsp_parity = ^shadow_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
